multi_lane_instruction_queue: RTL and testbench

- Parametrised in-order circular instruction queue between decode and rename/issue.
- Accepts up to N_IN instructions per cycle and presents up to N_OUT oldest entries per cycle.
- Generalises the fixed 2-wide queue with:
  - arbitrary lane counts;
  - non-power-of-two depth;
  - compaction of sparse input valids;
  - explicit ready/credit signalling and an almost-full threshold.

---
 rtl/multi_lane_instruction_queue_pkg.sv | 11 +
 rtl/multi_lane_instruction_queue_if.sv | 32 +++
 rtl/iq_lane_compactor.sv | 23 ++
 rtl/multi_lane_instruction_queue_sva.sv | 63 ++++++
 rtl/multi_lane_instruction_queue.sv | 135 +++++++++++++
 tb/tb_multi_lane_instruction_queue.sv | 176 +++++++++++++++++
 6 files changed

// File: rtl/multi_lane_instruction_queue_pkg.sv
// Shared constants and types for the multi-lane instruction queue between decode and rename.
package multi_lane_instruction_queue_pkg;

   localparam int INSTRUCTION_QUEUE_NUM_ENTRIES = 8;
   localparam int NUM_SCALAR_INSTR              = 2;
   localparam int IQ_DATA_W                     = 64;
   localparam int IQ_AF_THRESH                  = 6;

   typedef logic [$clog2(INSTRUCTION_QUEUE_NUM_ENTRIES + 1)-1:0] iq_count_t;

endpackage

// File: rtl/multi_lane_instruction_queue_if.sv
// Producer/consumer bundle of the instruction queue; the queue takes the slave side.
interface multi_lane_instruction_queue_if
   import multi_lane_instruction_queue_pkg::*;
#(
   parameter int DEPTH  = INSTRUCTION_QUEUE_NUM_ENTRIES,
   parameter int N_IN   = NUM_SCALAR_INSTR,
   parameter int N_OUT  = NUM_SCALAR_INSTR,
   parameter int DATA_W = IQ_DATA_W
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [N_IN-1:0]         in_valid_i;
   logic [N_IN*DATA_W-1:0]  in_data_i;
   logic                    in_ready_o;
   logic [N_OUT-1:0]        out_valid_o;
   logic [N_OUT*DATA_W-1:0] out_data_o;
   logic [N_OUT-1:0]        deq_i;
   logic [CNT_W-1:0]        count_o;
   logic                    empty_o;
   logic                    full_o;
   logic                    almost_full_o;

   modport master (
      output in_valid_i, in_data_i, deq_i,
      input  in_ready_o, out_valid_o, out_data_o, count_o, empty_o, full_o, almost_full_o
   );

   modport slave (
      input  in_valid_i, in_data_i, deq_i,
      output in_ready_o, out_valid_o, out_data_o, count_o, empty_o, full_o, almost_full_o
   );
endinterface

// File: rtl/iq_lane_compactor.sv
// Prefix popcount of the input valids: lane i writes at tail + (valid lanes below i).
module iq_lane_compactor
   import multi_lane_instruction_queue_pkg::*;
#(
   parameter int N_IN  = NUM_SCALAR_INSTR,
   localparam int OFF_W = $clog2(N_IN + 1)
) (
   input  logic [N_IN-1:0]  in_valid_i,
   output logic [OFF_W-1:0] wr_off_o [N_IN],
   output logic [OFF_W-1:0] n_wr_o
);
   logic [OFF_W-1:0] run_s;

   // Running count of valid lanes below each lane
   always_comb begin
      run_s = '0;
      for (int i = 0; i < N_IN; i++) begin
         wr_off_o[i] = run_s;
         run_s       = run_s + OFF_W'(in_valid_i[i]);
      end
      n_wr_o = run_s;
   end
endmodule

// File: rtl/multi_lane_instruction_queue_sva.sv
// Invariant checks on the queue pointers; also flags dequeue masks with a gap.
module multi_lane_instruction_queue_sva #(
   parameter int DEPTH = 8,
   parameter int N_OUT = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input logic             clk_i,
   input logic             rst_i,
   input logic [PTR_W-1:0] head_q_i,
   input logic [PTR_W-1:0] tail_q_i,
   input logic [CNT_W-1:0] count_q_i,
   input logic             in_ready_i,
   input logic             wr_en_i,
   input logic [N_OUT-1:0] deq_i,
   input logic [N_OUT-1:0] out_valid_i
);
   logic [PTR_W:0] diff_s;
   logic [PTR_W:0] cnt_mod_s;
   logic           hole_s;
   logic           gap_s;

   // Occupancy implied by the pointers versus the counter, both mod DEPTH
   always_comb begin
      if (tail_q_i >= head_q_i) begin
         diff_s = {1'b0, tail_q_i} - {1'b0, head_q_i};
      end else begin
         diff_s = {1'b0, tail_q_i} + (PTR_W+1)'(DEPTH) - {1'b0, head_q_i};
      end
      cnt_mod_s = (count_q_i == CNT_W'(DEPTH)) ? '0 : (PTR_W+1)'(count_q_i);
   end

   // A dequeue request above the first unpopped lane is a gap
   always_comb begin
      hole_s = 1'b0;
      gap_s  = 1'b0;
      for (int j = 0; j < N_OUT; j++) begin
         if (hole_s && deq_i[j]) begin
            gap_s = 1'b1;
         end else begin
            gap_s = gap_s;
         end
         if (!(deq_i[j] && out_valid_i[j])) begin
            hole_s = 1'b1;
         end else begin
            hole_s = hole_s;
         end
      end
   end

   a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
      count_q_i <= CNT_W'(DEPTH))
      else $error("count exceeds DEPTH");
   a_ptr_count: assert property (@(posedge clk_i) disable iff (rst_i)
      diff_s == cnt_mod_s)
      else $error("tail-head disagrees with count");
   a_no_wr_unready: assert property (@(posedge clk_i) disable iff (rst_i)
      wr_en_i |-> in_ready_i)
      else $error("write while not ready");
   a_deq_prefix: assert property (@(posedge clk_i) disable iff (rst_i)
      !gap_s)
      else $warning("deq_i has a gap; lanes above the first unpopped lane are ignored");
endmodule

// File: rtl/multi_lane_instruction_queue.sv
// In-order circular instruction queue: N_IN compacted enqueue lanes, N_OUT oldest-first output lanes.
module multi_lane_instruction_queue
   import multi_lane_instruction_queue_pkg::*;
#(
   parameter int DEPTH     = INSTRUCTION_QUEUE_NUM_ENTRIES,
   parameter int N_IN      = NUM_SCALAR_INSTR,
   parameter int N_OUT     = NUM_SCALAR_INSTR,
   parameter int DATA_W    = IQ_DATA_W,
   parameter int AF_THRESH = IQ_AF_THRESH
) (
   input logic clk_i,
   input logic rst_i,
   input logic flush_i,
   multi_lane_instruction_queue_if.slave q_if
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int SUM_W = PTR_W + 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int OFF_W = $clog2(N_IN + 1);
   localparam int RD_W  = $clog2(N_OUT + 1);

   logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [DATA_W-1:0]       mem_q [DEPTH];
   logic [OFF_W-1:0]        wr_off_s [N_IN];
   logic [OFF_W-1:0]        n_wr_s, n_acc_s;
   logic [RD_W-1:0]         n_rd_s;
   logic                    in_ready_s, wr_en_s, run_s;
   logic [N_OUT-1:0]        out_valid_s;
   logic [PTR_W-1:0]        wr_idx_s [N_IN];
   logic [PTR_W-1:0]        rd_idx_s [N_OUT];
   logic [N_OUT*DATA_W-1:0] out_data_s;

   // Single conditional subtract suffices: base < DEPTH and inc <= DEPTH
   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                 input logic [SUM_W-1:0] inc);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(base) + inc;
      if (sum >= SUM_W'(DEPTH)) begin
         sum = sum - SUM_W'(DEPTH);
      end else begin
         sum = sum;
      end
      return sum[PTR_W-1:0];
   endfunction

   iq_lane_compactor #(.N_IN(N_IN)) u_compactor (
      .in_valid_i (q_if.in_valid_i),
      .wr_off_o   (wr_off_s),
      .n_wr_o     (n_wr_s)
   );

   // Credit from registered count only; write and read slot addresses
   always_comb begin
      in_ready_s = (count_q <= CNT_W'(DEPTH - N_IN));
      n_acc_s    = in_ready_s ? n_wr_s : '0;
      wr_en_s    = in_ready_s && (n_wr_s != '0);
      for (int i = 0; i < N_IN; i++) begin
         wr_idx_s[i] = wrap_add(tail_q, SUM_W'(wr_off_s[i]));
      end
      for (int j = 0; j < N_OUT; j++) begin
         out_valid_s[j] = (count_q > CNT_W'(j));
         rd_idx_s[j]    = wrap_add(head_q, SUM_W'(j));
         out_data_s[j*DATA_W +: DATA_W] = out_valid_s[j] ? mem_q[rd_idx_s[j]] : '0;
      end
   end

   // Pop count is the leading run of requested-and-valid lanes
   always_comb begin
      run_s  = 1'b1;
      n_rd_s = '0;
      for (int j = 0; j < N_OUT; j++) begin
         if (run_s && q_if.deq_i[j] && out_valid_s[j]) begin
            n_rd_s = n_rd_s + RD_W'(1);
         end else begin
            run_s = 1'b0;
         end
      end
   end

   // Pointer and occupancy next state
   always_comb begin
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = wrap_add(head_q, SUM_W'(n_rd_s));
         tail_d  = wrap_add(tail_q, SUM_W'(n_acc_s));
         count_d = count_q + CNT_W'(n_acc_s) - CNT_W'(n_rd_s);
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload storage is deliberately left out of reset
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < N_IN; i++) begin
         if (in_ready_s && q_if.in_valid_i[i] && !flush_i) begin
            mem_q[wr_idx_s[i]] <= q_if.in_data_i[i*DATA_W +: DATA_W];
         end
      end
   end

   assign q_if.in_ready_o    = in_ready_s;
   assign q_if.out_valid_o   = out_valid_s;
   assign q_if.out_data_o    = out_data_s;
   assign q_if.count_o       = count_q;
   assign q_if.empty_o       = (count_q == '0);
   assign q_if.full_o        = (count_q == CNT_W'(DEPTH));
   assign q_if.almost_full_o = (count_q >= CNT_W'(AF_THRESH));

   multi_lane_instruction_queue_sva #(.DEPTH(DEPTH), .N_OUT(N_OUT)) u_sva (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .head_q_i    (head_q),
      .tail_q_i    (tail_q),
      .count_q_i   (count_q),
      .in_ready_i  (in_ready_s),
      .wr_en_i     (wr_en_s),
      .deq_i       (q_if.deq_i),
      .out_valid_i (out_valid_s)
   );
endmodule

// File: tb/tb_multi_lane_instruction_queue.sv
// Directed bench: an 8-entry queue for reset/compaction/back-pressure/flush and a 6-entry queue for wrap.
module tb_multi_lane_instruction_queue;
   import multi_lane_instruction_queue_pkg::*;

   logic clk = 1'b0;
   logic rst8, flush8, rst6, flush6;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   wr_seq, rd_seq;

   always #5 clk = ~clk;

   multi_lane_instruction_queue_if #(.DEPTH(8), .N_IN(2), .N_OUT(2), .DATA_W(64)) if8 ();
   multi_lane_instruction_queue_if #(.DEPTH(6), .N_IN(2), .N_OUT(2), .DATA_W(64)) if6 ();

   multi_lane_instruction_queue #(.DEPTH(8), .N_IN(2), .N_OUT(2), .DATA_W(64), .AF_THRESH(6)) u_dut8 (
      .clk_i (clk), .rst_i (rst8), .flush_i (flush8), .q_if (if8.slave)
   );
   multi_lane_instruction_queue #(.DEPTH(6), .N_IN(2), .N_OUT(2), .DATA_W(64), .AF_THRESH(4)) u_dut6 (
      .clk_i (clk), .rst_i (rst6), .flush_i (flush6), .q_if (if6.slave)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive8(input logic [1:0] v, input logic [63:0] d0, input logic [63:0] d1,
                         input logic [1:0] dq);
      if8.in_valid_i = v;
      if8.in_data_i  = {d1, d0};
      if8.deq_i      = dq;
   endtask

   task automatic drive6(input logic [1:0] v, input logic [63:0] d0, input logic [63:0] d1,
                         input logic [1:0] dq);
      if6.in_valid_i = v;
      if6.in_data_i  = {d1, d0};
      if6.deq_i      = dq;
   endtask

   initial begin
      rst8 = 1'b1; flush8 = 1'b0; rst6 = 1'b1; flush6 = 1'b0;
      drive8(2'b00, 64'h0, 64'h0, 2'b00);
      drive6(2'b00, 64'h0, 64'h0, 2'b00);
      tick(); tick();
      rst8 = 1'b0; rst6 = 1'b0;

      chk("rst_count",  64'(if8.count_o), 64'd0);
      chk("rst_empty",  64'(if8.empty_o), 64'd1);
      chk("rst_full",   64'(if8.full_o), 64'd0);
      chk("rst_af",     64'(if8.almost_full_o), 64'd0);
      chk("rst_ready",  64'(if8.in_ready_o), 64'd1);
      chk("rst_ovalid", 64'(if8.out_valid_o), 64'd0);
      chk("rst_odata",  if8.out_data_o[63:0] | if8.out_data_o[127:64], 64'd0);
      chk("rst6_count", 64'(if6.count_o), 64'd0);

      // Burst of 5, then reset while more traffic is offered
      drive8(2'b11, 64'h1, 64'h2, 2'b00); tick();
      drive8(2'b11, 64'h3, 64'h4, 2'b00); tick();
      drive8(2'b01, 64'h5, 64'h0, 2'b00); tick();
      drive8(2'b00, 64'h0, 64'h0, 2'b00);
      chk("burst_count", 64'(if8.count_o), 64'd5);
      chk("burst_lane0", if8.out_data_o[63:0], 64'h1);
      chk("burst_lane1", if8.out_data_o[127:64], 64'h2);
      chk("burst_af",    64'(if8.almost_full_o), 64'd0);
      drive8(2'b11, 64'h6, 64'h7, 2'b01);
      rst8 = 1'b1; tick(); rst8 = 1'b0;
      drive8(2'b00, 64'h0, 64'h0, 2'b00);
      chk("midrst_count",  64'(if8.count_o), 64'd0);
      chk("midrst_empty",  64'(if8.empty_o), 64'd1);
      chk("midrst_ovalid", 64'(if8.out_valid_o), 64'd0);
      chk("midrst_ready",  64'(if8.in_ready_o), 64'd1);

      // Sparse valid mask compacts into consecutive entries
      drive8(2'b10, 64'hEE, 64'hB, 2'b00); tick();
      drive8(2'b11, 64'hC, 64'hD, 2'b00); tick();
      drive8(2'b00, 64'h0, 64'h0, 2'b00);
      chk("sparse_lane0",  if8.out_data_o[63:0], 64'hB);
      chk("sparse_lane1",  if8.out_data_o[127:64], 64'hC);
      chk("sparse_count",  64'(if8.count_o), 64'd3);
      chk("sparse_ovalid", 64'(if8.out_valid_o), 64'd3);

      // Dequeue mask with a gap pops nothing; full prefix pops two
      drive8(2'b00, 64'h0, 64'h0, 2'b10); tick();
      chk("gap_count", 64'(if8.count_o), 64'd3);
      chk("gap_lane0", if8.out_data_o[63:0], 64'hB);
      drive8(2'b00, 64'h0, 64'h0, 2'b11); tick();
      drive8(2'b00, 64'h0, 64'h0, 2'b00);
      chk("pop2_count",  64'(if8.count_o), 64'd1);
      chk("pop2_lane0",  if8.out_data_o[63:0], 64'hD);
      chk("pop2_ovalid", 64'(if8.out_valid_o), 64'd1);
      chk("pop2_lane1",  if8.out_data_o[127:64], 64'd0);

      // Fill to 7 across the index 7->0 boundary
      drive8(2'b11, 64'h10, 64'h11, 2'b00); tick();
      drive8(2'b11, 64'h12, 64'h13, 2'b00); tick();
      chk("fill5_ready", 64'(if8.in_ready_o), 64'd1);
      drive8(2'b11, 64'h14, 64'h15, 2'b00); tick();
      drive8(2'b00, 64'h0, 64'h0, 2'b00);
      chk("fill7_count", 64'(if8.count_o), 64'd7);
      chk("fill7_ready", 64'(if8.in_ready_o), 64'd0);
      chk("fill7_full",  64'(if8.full_o), 64'd0);
      chk("fill7_af",    64'(if8.almost_full_o), 64'd1);
      chk("fill7_lane1", if8.out_data_o[127:64], 64'h10);

      // Dequeue gives no same-cycle credit; held data lands a cycle later
      drive8(2'b11, 64'hAA, 64'hBB, 2'b01);
      chk("bp_same_ready", 64'(if8.in_ready_o), 64'd0);
      tick();
      drive8(2'b11, 64'hAA, 64'hBB, 2'b00);
      chk("bp_count", 64'(if8.count_o), 64'd6);
      chk("bp_ready", 64'(if8.in_ready_o), 64'd1);
      chk("bp_lane0", if8.out_data_o[63:0], 64'h10);
      tick();
      drive8(2'b00, 64'h0, 64'h0, 2'b00);
      chk("full_count", 64'(if8.count_o), 64'd8);
      chk("full_full",  64'(if8.full_o), 64'd1);
      chk("full_ready", 64'(if8.in_ready_o), 64'd0);
      chk("full_lane1", if8.out_data_o[127:64], 64'h11);

      drive8(2'b00, 64'h0, 64'h0, 2'b11); tick(); tick();
      drive8(2'b00, 64'h0, 64'h0, 2'b00);
      chk("drain_count", 64'(if8.count_o), 64'd4);
      chk("drain_lane0", if8.out_data_o[63:0], 64'h14);
      chk("drain_lane1", if8.out_data_o[127:64], 64'h15);

      // Flush discards queued entries and same-cycle traffic
      drive8(2'b11, 64'h31, 64'h32, 2'b11);
      flush8 = 1'b1;
      chk("flush_ready", 64'(if8.in_ready_o), 64'd1);
      tick();
      flush8 = 1'b0;
      drive8(2'b00, 64'h0, 64'h0, 2'b00);
      chk("flush_count",  64'(if8.count_o), 64'd0);
      chk("flush_empty",  64'(if8.empty_o), 64'd1);
      chk("flush_ovalid", 64'(if8.out_valid_o), 64'd0);
      chk("flush_odata",  if8.out_data_o[63:0] | if8.out_data_o[127:64], 64'd0);
      drive8(2'b01, 64'h77, 64'h0, 2'b00); tick();
      drive8(2'b00, 64'h0, 64'h0, 2'b00);
      chk("post_flush_count", 64'(if8.count_o), 64'd1);
      chk("post_flush_lane0", if8.out_data_o[63:0], 64'h77);

      // 6-entry queue: offset by one so entry pairs straddle index 5->0
      drive6(2'b01, 64'd99, 64'd0, 2'b00); tick();
      chk("w6_prime_count", 64'(if6.count_o), 64'd1);
      chk("w6_prime_lane0", if6.out_data_o[63:0], 64'd99);
      drive6(2'b11, 64'd100, 64'd101, 2'b01); tick();
      wr_seq = 102;
      rd_seq = 100;
      for (int k = 0; k < 10; k++) begin
         drive6(2'b11, 64'(wr_seq), 64'(wr_seq + 1), 2'b11);
         chk("w6_lane0", if6.out_data_o[63:0], 64'(rd_seq));
         chk("w6_lane1", if6.out_data_o[127:64], 64'(rd_seq + 1));
         chk("w6_count", 64'(if6.count_o), 64'd2);
         tick();
         wr_seq = wr_seq + 2;
         rd_seq = rd_seq + 2;
      end
      drive6(2'b00, 64'h0, 64'h0, 2'b00);
      chk("w6_end_count", 64'(if6.count_o), 64'd2);
      chk("w6_end_lane0", if6.out_data_o[63:0], 64'd120);
      chk("w6_end_lane1", if6.out_data_o[127:64], 64'd121);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
